// File: rtl/flop_stim_pkg.sv
// Shared types and helpers for the flop systest stimulus/compare stage.
// FSM state encoding, LFSR constants and bit-rotation/LFSR step functions.
package flop_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] NOFAIL    = 16'hFFFF;

  function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned n);
    logic [31:0] dbl;
    dbl = {v, v} >> (n % 32'd16);
    return dbl[15:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/flop_stim_lfsr.sv
// 16-bit Galois LFSR: loads SEED on reset or load, advances on shift.
module flop_stim_lfsr
  import flop_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // LFSR state register; load has priority over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= SEED;
    end else if (shift) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/flop_stim_cmp.sv
// Drives LFSR stimulus into a spec/impl flop pair and compares their outputs.
// Optional macro FLOP_STIM_HOLD_EN adds a hold input that freezes RUN/DRAIN progress.
module flop_stim_cmp
  import flop_stim_pkg::*;
#(
  parameter int          SIZE    = 4,
  parameter int          NCYCLES = 64,
  parameter int          DRAIN   = 3,
  parameter int          WARMUP  = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef FLOP_STIM_HOLD_EN
  input  logic            hold,
`endif
  output logic [SIZE-1:0] d1,
  output logic [SIZE-1:0] d2,
  output logic [SIZE-1:0] d3,
  output logic            en,
  input  logic [SIZE-1:0] q_spec,
  input  logic [SIZE-1:0] q_impl,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     mismatch_count,
  output logic [15:0]     first_fail_cycle
);

  localparam logic [15:0] CYC_LAST   = 16'(NCYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = (DRAIN > 0) ? 16'(DRAIN - 1) : 16'h0000;
  localparam logic [15:0] WARM_CYC   = 16'(WARMUP);

  if (SIZE < 1 || SIZE > 16) begin : g_bad_size
    $error("flop_stim_cmp: SIZE must be 1..16");
  end
  if (NCYCLES < 1 || NCYCLES > 65535) begin : g_bad_ncycles
    $error("flop_stim_cmp: NCYCLES must be 1..65535");
  end
  if (DRAIN < 0 || WARMUP < 0 || (NCYCLES + DRAIN) > 65535) begin : g_bad_drain
    $error("flop_stim_cmp: NCYCLES + DRAIN must not exceed 65535");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("flop_stim_cmp: SEED must be nonzero");
  end

  state_e          state_r, state_s;
  logic [15:0]     cyc_r, dcnt_r;
  logic [SIZE-1:0] d1_r, d2_r, d3_r;
  logic            en_r, busy_r, done_r, pass_r;
  logic [15:0]     mcnt_r, ffc_r;
  logic [15:0]     lfsr_s;
  logic            hold_s, start_ok_s, active_s, shift_s, cmp_en_s, miss_s, enter_done_s;

`ifdef FLOP_STIM_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  flop_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok_s),
    .shift (shift_s),
    .value (lfsr_s)
  );

  // Next-state and per-cycle control decode
  always_comb begin
    state_s      = state_r;
    start_ok_s   = 1'b0;
    active_s     = 1'b0;
    shift_s      = 1'b0;
    cmp_en_s     = 1'b0;
    miss_s       = 1'b0;
    enter_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_ok_s = 1'b1;
          state_s    = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hold_s) begin
          state_s = ST_RUN;
        end else begin
          active_s = 1'b1;
          shift_s  = 1'b1;
          cmp_en_s = (cyc_r >= WARM_CYC);
          if (cyc_r == CYC_LAST) begin
            state_s = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (hold_s) begin
          state_s = ST_DRAIN;
        end else begin
          active_s = 1'b1;
          cmp_en_s = 1'b1;
          if (dcnt_r == DRAIN_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          start_ok_s = 1'b1;
          state_s    = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Case inequality so X/Z on either flop output is treated as a mismatch
    if (cmp_en_s) begin
      miss_s = (q_spec !== q_impl);
    end else begin
      miss_s = 1'b0;
    end
    if (state_s == ST_DONE && state_r != ST_DONE) begin
      enter_done_s = 1'b1;
    end else begin
      enter_done_s = 1'b0;
    end
  end

  // FSM state and status flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Cycle index and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r  <= 16'h0000;
      dcnt_r <= 16'h0000;
    end else if (start_ok_s) begin
      cyc_r  <= 16'h0000;
      dcnt_r <= 16'h0000;
    end else if (active_s) begin
      cyc_r  <= cyc_r + 16'h0001;
      dcnt_r <= (state_r == ST_DRAIN) ? dcnt_r + 16'h0001 : 16'h0000;
    end else begin
      cyc_r  <= cyc_r;
      dcnt_r <= dcnt_r;
    end
  end

  // Stimulus registers, driven from the LFSR value of the previous load/shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_r <= '0;
      d2_r <= '0;
      d3_r <= '0;
      en_r <= 1'b0;
    end else if (shift_s) begin
      d1_r <= SIZE'(lfsr_s);
      d2_r <= SIZE'(ror16(lfsr_s, 32'd5));
      d3_r <= ~SIZE'(lfsr_s);
      en_r <= lfsr_s[15];
    end else begin
      d1_r <= d1_r;
      d2_r <= d2_r;
      d3_r <= d3_r;
      en_r <= en_r;
    end
  end

  // Mismatch bookkeeping and final verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_r <= 16'h0000;
      ffc_r  <= NOFAIL;
      pass_r <= 1'b0;
    end else if (start_ok_s) begin
      mcnt_r <= 16'h0000;
      ffc_r  <= NOFAIL;
      pass_r <= 1'b0;
    end else begin
      if (miss_s && mcnt_r != 16'hFFFF) begin
        mcnt_r <= mcnt_r + 16'h0001;
      end else begin
        mcnt_r <= mcnt_r;
      end
      if (miss_s && ffc_r == NOFAIL) begin
        ffc_r <= cyc_r;
      end else begin
        ffc_r <= ffc_r;
      end
      // Fold in a mismatch seen on the very cycle that enters DONE
      if (enter_done_s) begin
        pass_r <= (mcnt_r == 16'h0000) && !miss_s;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign d1               = d1_r;
  assign d2               = d2_r;
  assign d3               = d3_r;
  assign en               = en_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign mismatch_count   = mcnt_r;
  assign first_fail_cycle = ffc_r;

endmodule

// File: tb/tb_flop_stim_cmp.sv
// Directed self-checking bench for flop_stim_cmp (SIZE=4, NCYCLES=64, DRAIN=3, WARMUP=2).
// Expected LFSR stimulus was computed by hand from SEED 16'hACE1.
module tb_flop_stim_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
`ifdef FLOP_STIM_HOLD_EN
  logic        hold;
`endif
  logic [3:0]  d1, d2, d3;
  logic        en;
  logic [3:0]  q_spec, q_impl;
  logic        busy, done, pass;
  logic [15:0] mismatch_count, first_fail_cycle;

  int n_checks = 0;
  int n_pass   = 0;
  int edges;
  logic [3:0] first_d1;

  flop_stim_cmp #(.SIZE(4), .NCYCLES(64), .DRAIN(3), .WARMUP(2), .SEED(16'hACE1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
`ifdef FLOP_STIM_HOLD_EN
    .hold             (hold),
`endif
    .d1               (d1),
    .d2               (d2),
    .d3               (d3),
    .en               (en),
    .q_spec           (q_spec),
    .q_impl           (q_impl),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_count   (mismatch_count),
    .first_fail_cycle (first_fail_cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full run; q_impl is driven per compare-cycle index k (valid while not held)
  task automatic run(input int fail_from, input int x_from, input int x_to,
                     input int extra_start, input int hold_from,
                     output int n_edges, output logic [3:0] d1_first);
    @(negedge clk);
    start  = 1'b1;
    q_impl = q_spec;
    @(posedge clk);
    #1 start = 1'b0;
    n_edges  = 0;
    d1_first = 4'h0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = (k == extra_start);
`ifdef FLOP_STIM_HOLD_EN
      hold = (k >= hold_from) && (k < hold_from + 5);
`endif
      if (k >= x_from && k <= x_to) q_impl = 4'bxxxx;
      else if (k >= fail_from)      q_impl = q_spec ^ 4'h1;
      else                          q_impl = q_spec;
      @(posedge clk);
      #1;
      n_edges++;
      if (n_edges == 1) d1_first = d1;
      if (done) break;
    end
    start  = 1'b0;
`ifdef FLOP_STIM_HOLD_EN
    hold   = 1'b0;
`endif
    q_impl = q_spec;
    chk("run_done_reached", {15'h0000, done}, 16'h0001);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
`ifdef FLOP_STIM_HOLD_EN
    hold   = 1'b0;
`endif
    q_spec = 4'h5;
    q_impl = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d1", {12'h000, d1}, 16'h0000);
    chk("rst_d2", {12'h000, d2}, 16'h0000);
    chk("rst_d3", {12'h000, d3}, 16'h0000);
    chk("rst_en", {15'h0000, en}, 16'h0000);
    chk("rst_busy", {15'h0000, busy}, 16'h0000);
    chk("rst_done", {15'h0000, done}, 16'h0000);
    chk("rst_pass", {15'h0000, pass}, 16'h0000);
    chk("rst_mcnt", mismatch_count, 16'h0000);
    chk("rst_ffc", first_fail_cycle, 16'hFFFF);
    @(negedge clk) rst_n = 1'b1;

    // First three stimulus vectors from SEED, then reset at cyc 10 with mismatches pending
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("lat_busy", {15'h0000, busy}, 16'h0001);
    chk("lat_d1_idle", {12'h000, d1}, 16'h0000);
    q_impl = 4'hA;
    @(posedge clk); #1;
    chk("s0_d1", {12'h000, d1}, 16'h0001);
    chk("s0_d2", {12'h000, d2}, 16'h0007);
    chk("s0_d3", {12'h000, d3}, 16'h000E);
    chk("s0_en", {15'h0000, en}, 16'h0001);
    @(posedge clk); #1;
    chk("s1_d1", {12'h000, d1}, 16'h0000);
    chk("s1_d2", {12'h000, d2}, 16'h0003);
    chk("s1_d3", {12'h000, d3}, 16'h000F);
    chk("s1_en", {15'h0000, en}, 16'h0001);
    @(posedge clk); #1;
    chk("s2_d1", {12'h000, d1}, 16'h0008);
    chk("s2_d2", {12'h000, d2}, 16'h0009);
    chk("s2_d3", {12'h000, d3}, 16'h0007);
    chk("s2_en", {15'h0000, en}, 16'h0000);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_mcnt", mismatch_count, 16'h0008);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'h0000, busy}, 16'h0000);
    chk("midrst_mcnt", mismatch_count, 16'h0000);
    chk("midrst_ffc", first_fail_cycle, 16'hFFFF);
    chk("midrst_d1", {12'h000, d1}, 16'h0000);
    chk("midrst_en", {15'h0000, en}, 16'h0000);
    q_impl = q_spec;
    @(negedge clk) rst_n = 1'b1;

    // Clean run from IDLE, with a start pulse during RUN that must be ignored
    run(1000, 1000, -1, 30, 1000, edges, first_d1);
    chk("clean_edges", 16'(edges), 16'd67);
    chk("clean_first_d1", {12'h000, first_d1}, 16'h0001);
    chk("clean_pass", {15'h0000, pass}, 16'h0001);
    chk("clean_mcnt", mismatch_count, 16'h0000);
    chk("clean_ffc", first_fail_cycle, 16'hFFFF);
    chk("clean_busy", {15'h0000, busy}, 16'h0000);
    @(posedge clk); #1;
    chk("done_holds", {15'h0000, done}, 16'h0001);

    // Restart from DONE with impl diverging from cyc 20 onward
    run(20, 1000, -1, -1, 1000, edges, first_d1);
    chk("fail_edges", 16'(edges), 16'd67);
    chk("fail_first_d1", {12'h000, first_d1}, 16'h0001);
    chk("fail_mcnt", mismatch_count, 16'd47);
    chk("fail_ffc", first_fail_cycle, 16'd20);
    chk("fail_pass", {15'h0000, pass}, 16'h0000);

    // X during warm-up only is ignored
    run(1000, 0, 1, -1, 1000, edges, first_d1);
    chk("xwarm_pass", {15'h0000, pass}, 16'h0001);
    chk("xwarm_mcnt", mismatch_count, 16'h0000);

    // X on the first compared cycle counts
    run(1000, 2, 2, -1, 1000, edges, first_d1);
    chk("x2_mcnt", mismatch_count, 16'h0001);
    chk("x2_ffc", first_fail_cycle, 16'h0002);
    chk("x2_pass", {15'h0000, pass}, 16'h0000);

    // Mismatch only in the final DRAIN cycle still clears pass
    run(66, 1000, -1, -1, 1000, edges, first_d1);
    chk("lastdrain_mcnt", mismatch_count, 16'h0001);
    chk("lastdrain_ffc", first_fail_cycle, 16'd66);
    chk("lastdrain_pass", {15'h0000, pass}, 16'h0000);

`ifdef FLOP_STIM_HOLD_EN
    run(1000, 1000, -1, -1, 30, edges, first_d1);
    chk("hold_edges", 16'(edges), 16'd72);
    chk("hold_pass", {15'h0000, pass}, 16'h0001);
    chk("hold_mcnt", mismatch_count, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
